// File: rtl/vote_session_ctrl.sv
// Voting session controller: one vote per armed session, with timeout, post-vote
// lockout and saturating per-candidate and total tallies.
module vote_session_ctrl #(
  parameter int N_CAND  = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000,
  parameter int HOLD    = 50
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  input  logic [N_CAND-1:0]         vote_p,
  input  logic [$clog2(N_CAND)-1:0] sel,
  output logic                      armed,
  output logic                      busy,
  output logic                      vote_ok,
  output logic                      vote_err,
  output logic                      expired,
  output logic [$clog2(N_CAND)-1:0] last_cand,
  output logic [CNT_W-1:0]          tally_out,
  output logic [CNT_W-1:0]          total
);
  localparam int SEL_W = $clog2(N_CAND);
  localparam int TMR_W = $clog2(TIMEOUT + HOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RECORD, S_HOLD} state_t;

  state_t           state, state_nx;
  logic [TMR_W-1:0] timer;
  logic [SEL_W-1:0] idx;
  logic [CNT_W-1:0] tally [N_CAND];
  logic             one_hot, multi, timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [SEL_W-1:0] encode(input logic [N_CAND-1:0] v);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = 0; i < N_CAND; i++)
      if (v[i]) r = SEL_W'(i);
    return r;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi       = (vote_p & (vote_p - 1'b1)) != '0;
  assign one_hot     = (vote_p != '0) && !multi;
  assign timeout_hit = (timer == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (arm) state_nx = S_ARMED;
      S_ARMED:  begin
        if (one_hot)          state_nx = S_RECORD;
        else if (timeout_hit) state_nx = S_IDLE;
      end
      S_RECORD: state_nx = S_HOLD;
      S_HOLD:   if (timer == TMR_W'(HOLD - 1)) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    armed = (state == S_ARMED);
    busy  = (state == S_RECORD) || (state == S_HOLD);
  end

  // A valid vote on the timeout edge wins, so expiry requires no one-hot vote.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer     <= '0;
      idx       <= '0;
      last_cand <= '0;
      total     <= '0;
      vote_ok   <= 1'b0;
      vote_err  <= 1'b0;
      expired   <= 1'b0;
      for (int i = 0; i < N_CAND; i++) tally[i] <= '0;
    end else begin
      vote_ok  <= (state == S_RECORD);
      vote_err <= (state == S_ARMED) && multi;
      expired  <= (state == S_ARMED) && !one_hot && timeout_hit;
      case (state)
        S_IDLE:  timer <= '0;
        S_ARMED: begin
          if (one_hot) begin
            idx   <= encode(vote_p);
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RECORD: begin
          tally[idx] <= sat_inc(tally[idx]);
          total      <= sat_inc(total);
          last_cand  <= idx;
          timer      <= '0;
        end
        S_HOLD:  timer <= timer + 1'b1;
        default: timer <= '0;
      endcase
    end
  end

  always_comb begin
    tally_out = '0;
    for (int i = 0; i < N_CAND; i++)
      if (sel == SEL_W'(i)) tally_out = tally[i];
  end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: two instances (default widths, and a 2-bit counter
// variant with short timeout/lockout) driven together against a behavioural model.
module tb_vote_session_ctrl;
  logic       clk = 1'b0;
  logic       rst, arm;
  logic [3:0] vote_p;
  logic [1:0] sel;

  logic        armed_a, busy_a, ok_a, err_a, exp_a;
  logic [1:0]  last_a;
  logic [15:0] tally_a, total_a;
  logic        armed_b, busy_b, ok_b, err_b, exp_b;
  logic [1:0]  last_b;
  logic [1:0]  tally_b, total_b;

  vote_session_ctrl dut_a (
    .clk(clk), .rst(rst), .arm(arm), .vote_p(vote_p), .sel(sel),
    .armed(armed_a), .busy(busy_a), .vote_ok(ok_a), .vote_err(err_a),
    .expired(exp_a), .last_cand(last_a), .tally_out(tally_a), .total(total_a)
  );

  vote_session_ctrl #(.N_CAND(4), .CNT_W(2), .TIMEOUT(20), .HOLD(3)) dut_b (
    .clk(clk), .rst(rst), .arm(arm), .vote_p(vote_p), .sel(sel),
    .armed(armed_b), .busy(busy_b), .vote_ok(ok_b), .vote_err(err_b),
    .expired(exp_b), .last_cand(last_b), .tally_out(tally_b), .total(total_b)
  );

  always #5 clk = ~clk;

  logic        o_armed [2], o_busy [2], o_ok [2], o_err [2], o_exp [2];
  logic [1:0]  o_last  [2];
  logic [15:0] o_tally [2], o_total [2];
  assign o_armed[0] = armed_a;  assign o_armed[1] = armed_b;
  assign o_busy[0]  = busy_a;   assign o_busy[1]  = busy_b;
  assign o_ok[0]    = ok_a;     assign o_ok[1]    = ok_b;
  assign o_err[0]   = err_a;    assign o_err[1]   = err_b;
  assign o_exp[0]   = exp_a;    assign o_exp[1]   = exp_b;
  assign o_last[0]  = last_a;   assign o_last[1]  = last_b;
  assign o_tally[0] = tally_a;  assign o_tally[1] = {14'b0, tally_b};
  assign o_total[0] = total_a;  assign o_total[1] = {14'b0, total_b};

  int vecs = 0;
  int errs = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 waiting for a vote, 2 recording, 3 lockout.
  int TO   [2] = '{1000, 20};
  int HD   [2] = '{50, 3};
  int MAXC [2] = '{65535, 3};
  int md [2], waited [2], held [2], pend [2];
  int mt [2][4];
  int e_total [2], e_last [2];
  bit e_ok [2], e_err [2], e_exp [2];
  bit mvalid = 1'b0;

  task automatic model_step();
    int n;
    for (int m = 0; m < 2; m++) begin
      e_ok[m] = 1'b0; e_err[m] = 1'b0; e_exp[m] = 1'b0;
      if (rst) begin
        md[m] = 0; e_total[m] = 0; e_last[m] = 0;
        for (int c = 0; c < 4; c++) mt[m][c] = 0;
      end else begin
        case (md[m])
          0: if (arm) begin md[m] = 1; waited[m] = 0; end
          1: begin
            n = $countones(vote_p);
            if (n == 1) begin
              md[m] = 2; pend[m] = $clog2(vote_p);
            end else begin
              if (n > 1) e_err[m] = 1'b1;
              if (waited[m] == TO[m] - 1) begin md[m] = 0; e_exp[m] = 1'b1; end
              else waited[m]++;
            end
          end
          2: begin
            if (mt[m][pend[m]] < MAXC[m]) mt[m][pend[m]]++;
            if (e_total[m] < MAXC[m]) e_total[m]++;
            e_last[m] = pend[m]; e_ok[m] = 1'b1; md[m] = 3; held[m] = 0;
          end
          default: if (held[m] == HD[m] - 1) md[m] = 0; else held[m]++;
        endcase
      end
    end
    if (rst) mvalid = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      for (int m = 0; m < 2; m++) begin
        check($sformatf("armed%0d", m), 32'(o_armed[m]), 32'(md[m] == 1));
        check($sformatf("busy%0d", m),  32'(o_busy[m]),  32'(md[m] >= 2));
        check($sformatf("vote_ok%0d", m),  32'(o_ok[m]),  32'(e_ok[m]));
        check($sformatf("vote_err%0d", m), 32'(o_err[m]), 32'(e_err[m]));
        check($sformatf("expired%0d", m),  32'(o_exp[m]), 32'(e_exp[m]));
        check($sformatf("last_cand%0d", m), 32'(o_last[m]), e_last[m]);
        check($sformatf("total%0d", m),     32'(o_total[m]), e_total[m]);
        check($sformatf("tally_out%0d", m), 32'(o_tally[m]), mt[m][sel]);
      end
    end
  end

  task automatic step(input logic r, input logic a, input logic [3:0] v, input logic [1:0] s);
    rst = r; arm = a; vote_p = v; sel = s;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] v, input logic [1:0] s);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, v, s);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; vote_p = '0; sel = '0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_armed", 32'(armed_a), 0);
    check("rst_total", 32'(total_a), 0);
    check("rst_tally", 32'(tally_b), 0);

    // Single vote for candidate 1, then the 50-cycle lockout with stray votes.
    step(0, 1, 4'b0000, 1);
    check("t1_armed", 32'(armed_a), 1);
    step(0, 0, 4'b0010, 1);
    check("t1_ok_not_yet", 32'(ok_a), 0);
    step(0, 0, 4'b0000, 1);
    check("t1_ok", 32'(ok_a), 1);
    check("t1_tally1", 32'(tally_a), 1);
    check("t1_total", 32'(total_a), 1);
    check("t1_last", 32'(last_a), 1);
    idle(49, 4'b0001, 0);
    check("t1_hold_end", 32'(busy_a), 1);
    step(0, 0, 4'b0001, 0);
    check("t1_idle", 32'(busy_a), 0);
    check("t4_total", 32'(total_a), 1);
    step(0, 0, 4'b0001, 0);
    idle(1, 4'b0000, 0);
    check("t4_idle_total", 32'(total_a), 1);

    // Multi-button rejection, then a valid vote for candidate 3.
    step(0, 1, 4'b0000, 3);
    step(0, 0, 4'b0101, 3);
    check("t2_err", 32'(err_a), 1);
    check("t2_armed", 32'(armed_a), 1);
    check("t2_total", 32'(total_a), 1);
    step(0, 0, 4'b1000, 3);
    step(0, 0, 4'b0000, 3);
    check("t2_ok", 32'(ok_a), 1);
    check("t2_tally3", 32'(tally_a), 1);
    idle(52, 4'b0000, 3);

    // Timeout after 1000 armed cycles, then a late vote is ignored.
    step(0, 1, 4'b0000, 0);
    idle(999, 4'b0000, 0);
    check("t3_still_armed", 32'(armed_a), 1);
    check("t3_no_exp_yet", 32'(exp_a), 0);
    step(0, 0, 4'b0000, 0);
    check("t3_expired", 32'(exp_a), 1);
    check("t3_disarmed", 32'(armed_a), 0);
    step(0, 0, 4'b0001, 0);
    step(0, 0, 4'b0000, 0);
    check("t3_late_vote", 32'(total_a), 2);

    // Four votes for candidate 0: the 2-bit instance saturates.
    for (int s = 0; s < 4; s++) begin
      step(0, 1, 4'b0000, 0);
      step(0, 0, 4'b0001, 0);
      step(0, 0, 4'b0000, 0);
      check("t5_ok_b", 32'(ok_b), 1);
      idle(52, 4'b0000, 0);
    end
    check("t5_tally0_b", 32'(tally_b), 3);
    check("t5_total_b", 32'(total_b), 3);
    check("t5_tally0_a", 32'(tally_a), 4);
    check("t5_total_a", 32'(total_a), 6);

    // Reset while armed and while in lockout.
    step(0, 1, 4'b0000, 0);
    step(1, 0, 4'b0000, 0);
    check("t6_armed_rst", 32'(armed_a), 0);
    check("t6_tally_rst", 32'(tally_a), 0);
    check("t6_total_rst", 32'(total_a), 0);
    step(0, 1, 4'b0000, 2);
    step(0, 0, 4'b0100, 2);
    step(0, 0, 4'b0000, 2);
    step(0, 0, 4'b0000, 2);
    step(1, 0, 4'b0000, 2);
    check("t6_busy_rst", 32'(busy_a), 0);
    check("t6_total_hold_rst", 32'(total_a), 0);
    check("t6_ok_rst", 32'(ok_a), 0);

    // Randomized traffic checked by the model on every cycle.
    for (int i = 0; i < 20000; i++) begin
      logic       r, a;
      logic [3:0] v;
      int         k;
      r = ($urandom_range(0, 999) == 0);
      a = ($urandom_range(0, 9) == 0);
      k = $urandom_range(0, 19);
      if (k < 2)      v = 4'($urandom_range(0, 15));
      else if (k < 4) v = 4'(1 << $urandom_range(0, 3));
      else            v = 4'b0000;
      step(r, a, v, 2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
